midi_uart_rx: RTL and testbench
===============================

// Module: midi_uart_rx
// PURPOSE
//  Serial MIDI front end: samples the 31.25 kbaud MIDI IN line and assembles complete channel
//  messages into a MIDI_BYTES-wide event word {status, data1, data2}.
//  Feeds the MIDI voice/ADSR stage, which updates on any change of the event word.
//  Handles running status, interleaved real-time bytes, SysEx skipping and note-on velocity 0.
// PARAMETERS
//  CLKS_PER_BIT  3146  clk_in cycles per serial bit (98.304 MHz / 31250 baud, rounded)
//  MIDI_CHANNEL  0     4-bit channel accepted when MIDI_OMNI_EN is undefined
// PORTS
//  clk_in           in   1           system clock, single clock domain
//  rst_in           in   1           synchronous, active-high reset
//  midi_rx_in       in   1           asynchronous serial MIDI line, idle high
//  midi_event       out  MIDI_BYTES  last complete message {status[23:16], d1[15:8], d2[7:0]}
//  event_valid_out  out  1           1-cycle pulse in the cycle midi_event updates
//  framing_err_out  out  1           1-cycle pulse when a stop bit samples low
// BEHAVIOUR
//  Reset: midi_event=0, event_valid_out=0, framing_err_out=0, running status=0 (none),
//   data count=0, both sync flops=1, receiver state=WAIT_HIGH. Reset mid-byte drops the partial byte.
//  Input sync: two flops on midi_rx_in. All receiver logic uses the second flop (rx_s).
//  Receiver FSM, with a bit counter of width clog2(CLKS_PER_BIT) and a 3-bit index:
//   WAIT_HIGH: go to IDLE when rx_s==1.
//   IDLE: rx_s==0 -> START and clear the counter.
//   START: at count CLKS_PER_BIT/2, rx_s==0 -> DATA; rx_s==1 -> IDLE (glitch rejected).
//   DATA: sample every CLKS_PER_BIT cycles. 8 bits, LSB first. After bit 7 -> STOP.
//   STOP: one CLKS_PER_BIT after bit 7, sample rx_s.
//    rx_s==1: pulse internal byte_valid with the byte, then -> IDLE.
//    rx_s==0: pulse framing_err_out and drop the byte, then -> WAIT_HIGH.
//  Parser, acting on byte_valid with byte b:
//   b>=F8 (real-time): ignored. Running status and the partial message are untouched.
//   F0..F7 (system/SysEx): clear running status and data count. Later data bytes are dropped.
//   80..EF (channel status): load running status, clear data count.
//    Expected data length: 1 for Cx/Dx, 2 for all others.
//   00..7F (data): dropped if running status==0.
//    Otherwise store as d1 (count 0) or d2 (count 1).
//    When the count reaches the expected length, the message completes and the count resets to 0.
//    Running status is retained, so subsequent data bytes form new messages.
//  Emit, registered one cycle after the byte_valid of the completing byte:
//   midi_event <= {status, d1, d2}. d2=00 for 1-data messages. event_valid_out pulses for 1 cycle.
//   Note-on (9x) with d2==00 is emitted as {8'h8x, d1, 8'h00}.
//   midi_event holds its value between messages. It never returns to 0 except on reset.
//  End-to-end latency: the final stop-bit sample cycle + 1 clk_in.
//  A status byte arriving mid-message discards the partial message.
//  framing_err_out does not alter parser state.
// CONFIGURATION
//  MIDI_OMNI_EN defined: messages on every channel are accepted.
//   The status low nibble is forced to 0 on output (downstream stage decodes channel 0 only).
//  MIDI_OMNI_EN undefined: only status low nibble == MIDI_CHANNEL completes a message.
//   Other channels still update running status and byte counting, but emit nothing.
//   Emitted status keeps its real nibble.
// TESTING
//  Bytes 90 3C 64 at CLKS_PER_BIT -> one event_valid_out, midi_event=24'h903C64.
//  Running status 90 3C 64 40 00 -> events 903C64, then 804000 (velocity 0 remapped).
//  Bytes 90 3C F8 64 -> single event 903C64. F8 produces no event.
//  C0 05 -> C00500. Then F0 01 02 F7 3E -> no event (running status cleared).
//  Stop bit driven low -> framing_err_out pulse, no event. Next 80 3C 00 -> event 803C00.
//  Assert rst_in during bit 4 of a byte, then send 93 40 7F: outputs are 0 after reset;
//   event 934000+7F without MIDI_OMNI_EN (MIDI_CHANNEL=3) and 90407F with it.

Source files
------------

// File: rtl/midi_uart_rx_if.sv
// midi_uart_rx_if
//   Bundles the serial MIDI input line and the parsed-event outputs of
//   midi_uart_rx so the receiver and its consumer share one port.
// Signals
//   midi_rx_in      serial MIDI line, idle high (driven by the line side)
//   midi_event      last complete message {status, d1, d2}
//   event_valid_out 1-cycle pulse in the cycle midi_event updates
//   framing_err_out 1-cycle pulse when a stop bit samples low
//   rx_state        receiver FSM state, for observation only
// Modports
//   master  receiver side (drives the event outputs)
//   slave   line/consumer side (drives midi_rx_in)
// Handshake: there is no back-pressure. event_valid_out qualifies
//   midi_event for exactly one cycle; the consumer must take it then.
//   midi_event stays stable between pulses.
interface midi_uart_rx_if #(
    parameter int MIDI_BYTES = 24
);
    logic                  midi_rx_in;
    logic [MIDI_BYTES-1:0] midi_event;
    logic                  event_valid_out;
    logic                  framing_err_out;
    logic [2:0]            rx_state;

    modport master (
        input  midi_rx_in,
        output midi_event,
        output event_valid_out,
        output framing_err_out,
        output rx_state
    );

    modport slave (
        output midi_rx_in,
        input  midi_event,
        input  event_valid_out,
        input  framing_err_out,
        input  rx_state
    );
endinterface

// File: rtl/midi_uart_rx.sv
// midi_uart_rx
//   Serial MIDI front end. Synchronises the MIDI IN line, receives 8N1 bytes
//   at CLKS_PER_BIT clocks per bit, and assembles channel messages into a
//   24-bit event word {status, d1, d2}. Handles running status, real-time
//   bytes interleaved inside messages, SysEx skipping and note-on velocity 0
//   (remapped to note-off).
// Ports
//   clk_in   system clock
//   rst_in   synchronous active-high reset
//   bus      midi_uart_rx_if.master: midi_rx_in in; midi_event,
//            event_valid_out, framing_err_out, rx_state out
// Configuration
//   MIDI_OMNI_EN defined: every channel accepted, status low nibble forced
//   to 0 on output. Undefined: only MIDI_CHANNEL completes messages, and
//   emitted status keeps its real nibble.
module midi_uart_rx #(
    parameter int         CLKS_PER_BIT = 3146,
    parameter logic [3:0] MIDI_CHANNEL = 4'd0
) (
    input  logic              clk_in,
    input  logic              rst_in,
    midi_uart_rx_if.master    bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        WAIT_HIGH = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        STOP      = 3'd4
    } rx_state_t;

    logic            sync1_q, sync1_d;
    logic            rx_s_q, rx_s_d;
    rx_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            ferr_q, ferr_d;
    logic [7:0]      rs_q, rs_d;      // running status, 0 = none
    logic            dcnt_q, dcnt_d;  // data bytes held for current message
    logic [7:0]      d1_q, d1_d;
    logic [23:0]     event_q, event_d;
    logic            valid_q, valid_d;

    logic            byte_valid;
    logic            one_data;
    logic            chan_ok;
    logic [7:0]      msg_d1, msg_d2, msg_st;

    always_comb begin
        sync1_d  = bus.midi_rx_in;
        rx_s_d   = sync1_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        ferr_d   = 1'b0;
        rs_d     = rs_q;
        dcnt_d   = dcnt_q;
        d1_d     = d1_q;
        event_d  = event_q;
        valid_d  = 1'b0;
        byte_valid = 1'b0;
        one_data = (rs_q[7:4] == 4'hC) || (rs_q[7:4] == 4'hD);
        msg_d1   = 8'h00;
        msg_d2   = 8'h00;
        msg_st   = rs_q;
`ifdef MIDI_OMNI_EN
        chan_ok  = 1'b1;
`else
        chan_ok  = (rs_q[3:0] == MIDI_CHANNEL);
`endif

        // Receiver
        case (state_q)
            WAIT_HIGH: if (rx_s_q) state_d = IDLE;
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                // Mid-start-bit check rejects short glitches on the line.
                if (cnt_q == HALF_CNT) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = rx_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};  // LSB first
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        byte_valid = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = WAIT_HIGH;
        endcase

        // Parser: the received byte is shift_q in the byte_valid cycle.
        if (byte_valid) begin
            if (shift_q >= 8'hF8) begin
                // real-time: leaves the message in progress untouched
            end else if (shift_q >= 8'hF0) begin
                rs_d   = 8'h00;
                dcnt_d = 1'b0;
            end else if (shift_q[7]) begin
                rs_d   = shift_q;
                dcnt_d = 1'b0;
            end else if (rs_q != 8'h00) begin
                if (!dcnt_q && !one_data) begin
                    d1_d   = shift_q;
                    dcnt_d = 1'b1;
                end else begin
                    dcnt_d = 1'b0;
                    msg_d1 = one_data ? shift_q : d1_q;
                    msg_d2 = one_data ? 8'h00   : shift_q;
                    if (rs_q[7:4] == 4'h9 && msg_d2 == 8'h00) msg_st[7:4] = 4'h8;
`ifdef MIDI_OMNI_EN
                    msg_st[3:0] = 4'h0;
`endif
                    if (chan_ok) begin
                        event_d = {msg_st, msg_d1, msg_d2};
                        valid_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            state_q <= WAIT_HIGH;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            ferr_q  <= 1'b0;
            rs_q    <= 8'h00;
            dcnt_q  <= 1'b0;
            d1_q    <= 8'h00;
            event_q <= 24'h0;
            valid_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            rx_s_q  <= rx_s_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            ferr_q  <= ferr_d;
            rs_q    <= rs_d;
            dcnt_q  <= dcnt_d;
            d1_q    <= d1_d;
            event_q <= event_d;
            valid_q <= valid_d;
        end
    end

    assign bus.midi_event      = event_q;
    assign bus.event_valid_out = valid_q;
    assign bus.framing_err_out = ferr_q;
    assign bus.rx_state        = state_q;
endmodule

// File: tb/tb_midi_uart_rx.sv
module tb_midi_uart_rx;
    localparam int         C  = 16;
    localparam logic [3:0] CH = 4'd3;
    localparam int         NV = 10;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    midi_uart_rx_if bus ();

    midi_uart_rx #(
        .CLKS_PER_BIT(C),
        .MIDI_CHANNEL(CH)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bus)
    );

    typedef struct packed {
        int              n;
        logic [47:0]     bytes;
        int              ne;
        logic [1:0][23:0] ev;
    } vec_t;

    vec_t        tbl [NV];
    logic [23:0] exp_q [$];
    logic [23:0] last_ev = 24'h0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ev_cyc = 0;
    int start_cyc = 0;
    int ferr_cnt = 0;
    logic prev_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] cfg(input logic [23:0] e);
        logic [23:0] r;
        r = e;
`ifdef MIDI_OMNI_EN
        r[19:16] = 4'h0;
`endif
        return r;
    endfunction

    function automatic vec_t mk(input int n, input logic [47:0] b, input int ne,
                                input logic [23:0] e0, input logic [23:0] e1);
        vec_t v;
        v.n = n; v.bytes = b; v.ne = ne;
        v.ev[0] = e0; v.ev[1] = e1;
        return v;
    endfunction

    always @(posedge clk) cyc++;

    // scoreboard / monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.event_valid_out) begin
                ev_cyc = cyc;
                chk("pulse_width", {31'b0, prev_valid}, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got %h expected none", bus.midi_event);
                end else begin
                    chk("event", {8'h0, bus.midi_event}, {8'h0, exp_q.pop_front()});
                end
            end
            if (bus.framing_err_out) ferr_cnt++;
        end
        prev_valid = bus.event_valid_out;
    end

    // driver: called at a negedge, returns at a negedge with the line idle
    task automatic send_byte(input logic [7:0] b, input logic stop);
        bus.midi_rx_in = 1'b0;
        start_cyc = cyc;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.midi_rx_in = b[i];
            repeat (C) @(negedge clk);
        end
        bus.midi_rx_in = stop;
        repeat (C) @(negedge clk);
        bus.midi_rx_in = 1'b1;
    endtask

    task automatic drain(input string name);
        repeat (2 * C) @(negedge clk);
        chk(name, exp_q.size(), 0);
        exp_q.delete();
        chk("hold", {8'h0, bus.midi_event}, {8'h0, last_ev});
    endtask

    task automatic expect_ev(input logic [23:0] e);
        exp_q.push_back(cfg(e));
        last_ev = cfg(e);
    endtask

    initial begin
        int f0;
        int lat;
        logic [7:0] rb;

        tbl[0] = mk(3, 48'h933C64_000000, 1, 24'h933C64, 24'h0);
        tbl[1] = mk(5, 48'h933C64_400000, 2, 24'h933C64, 24'h834000);
        tbl[2] = mk(4, 48'h933CF8_640000, 1, 24'h933C64, 24'h0);
        tbl[3] = mk(2, 48'hC30500_000000, 1, 24'hC30500, 24'h0);
        tbl[4] = mk(5, 48'hF00102_F73E00, 0, 24'h0, 24'h0);
        tbl[5] = mk(4, 48'hB30710_110000, 1, 24'hB30710, 24'h0);
        tbl[6] = mk(3, 48'hD32021_000000, 2, 24'hD32000, 24'hD32100);
`ifdef MIDI_OMNI_EN
        tbl[7] = mk(3, 48'h953C64_000000, 1, 24'h953C64, 24'h0);
`else
        tbl[7] = mk(3, 48'h953C64_000000, 0, 24'h0, 24'h0);
`endif
        tbl[8] = mk(5, 48'h933C83_400000, 1, 24'h834000, 24'h0);
        tbl[9] = mk(3, 48'hE30040_000000, 1, 24'hE30040, 24'h0);

        bus.midi_rx_in = 1'b1;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_event", {8'h0, bus.midi_event}, 0);
        chk("rst_valid", {31'b0, bus.event_valid_out}, 0);
        chk("rst_ferr", {31'b0, bus.framing_err_out}, 0);
        repeat (4) @(negedge clk);

        // short low glitch: rejected at the mid-start-bit check
        f0 = ferr_cnt;
        bus.midi_rx_in = 1'b0;
        repeat (C / 4) @(negedge clk);
        bus.midi_rx_in = 1'b1;
        repeat (2 * C) @(negedge clk);
        chk("glitch_ferr", ferr_cnt - f0, 0);
        chk("glitch_event", {8'h0, bus.midi_event}, 0);

        // table-driven message vectors
        for (int v = 0; v < NV; v++) begin
            for (int e = 0; e < tbl[v].ne; e++) expect_ev(tbl[v].ev[e]);
            for (int i = 0; i < tbl[v].n; i++) begin
                rb = tbl[v].bytes[47 - 8 * i -: 8];
                send_byte(rb, 1'b1);
            end
            drain("vec_drain");
        end

        // end-to-end latency: event must follow the stop-bit sample
        expect_ev(24'h933C64);
        send_byte(8'h93, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h64, 1'b1);
        drain("lat_drain");
        lat = ev_cyc - start_cyc;
        chk("latency_window", {31'b0, (lat >= 9 * C + 1) && (lat <= 10 * C + 1)}, 1);

        // framing error: stop bit low, byte dropped, parser untouched
        f0 = ferr_cnt;
        send_byte(8'h93, 1'b0);
        repeat (2 * C) @(negedge clk);
        chk("ferr_count", ferr_cnt - f0, 1);
        chk("ferr_hold", {8'h0, bus.midi_event}, {8'h0, last_ev});
        expect_ev(24'h833C00);
        send_byte(8'h83, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h00, 1'b1);
        drain("ferr_next");

        // reset during data bit 4
        rb = 8'h93;
        bus.midi_rx_in = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.midi_rx_in = rb[i];
            repeat (C) @(negedge clk);
        end
        bus.midi_rx_in = rb[4];
        repeat (C / 2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        bus.midi_rx_in = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_ev = 24'h0;
        @(negedge clk);
        chk("mid_rst_event", {8'h0, bus.midi_event}, 0);
        chk("mid_rst_valid", {31'b0, bus.event_valid_out}, 0);
        chk("mid_rst_ferr", {31'b0, bus.framing_err_out}, 0);
        repeat (C) @(negedge clk);
        // running status cleared by reset: lone data bytes are dropped
        send_byte(8'h40, 1'b1);
        send_byte(8'h7F, 1'b1);
        drain("rst_no_rs");
        expect_ev(24'h93407F);
        send_byte(8'h93, 1'b1);
        send_byte(8'h40, 1'b1);
        send_byte(8'h7F, 1'b1);
        drain("rst_next");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
